// File: rtl/arith_defs_pkg.sv
// Shared arithmetic definitions for the sequential
// divider: FSM encoding and two's-complement helpers.
package arith_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_BITS = 4;

    function automatic logic [31:0] min_val(
        input int n
    );
        return 32'd1 << (n - 1);
    endfunction

    function automatic logic [31:0] negate(
        input logic [31:0] x
    );
        return ~x + 32'd1;
    endfunction

    // Caller truncates to n bits; |MIN| fits unsigned.
    function automatic logic [31:0] abs_val(
        input logic [31:0] x,
        input int          n
    );
        return x[n-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step on magnitudes:
// shift in a dividend bit, trial subtract, keep or restore.
module div_restore_step
    import arith_defs::*;
#(
    parameter int numBits = DEF_BITS
) (
    input  logic [numBits:0]   partial_rem,
    input  logic               next_bit,
    input  logic [numBits-1:0] divisor_mag,
    output logic [numBits:0]   new_rem,
    output logic               q_bit
);

    logic [numBits+1:0] shifted;
    logic [numBits:0]   diff;

    always_comb begin
        shifted = {partial_rem, next_bit};
        q_bit   = (shifted >= {2'b00, divisor_mag});
        diff    = shifted[numBits:0]
                - {1'b0, divisor_mag};
        new_rem = q_bit ? diff : shifted[numBits:0];
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Iterative signed divider, one quotient bit per clock,
// with ready/valid handshakes on operands and result.
module signed_seq_divider
    import arith_defs::*;
#(
    parameter int numBits = DEF_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [numBits-1:0] dividend,
    input  logic [numBits-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [numBits-1:0] quotient,
    output logic [numBits-1:0] remainder,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CW = $clog2(numBits) + 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [numBits:0]   rem_q, rem_d;
    logic [numBits-1:0] dvd_q, dvd_d;
    logic [numBits-1:0] dvs_q, dvs_d;
    logic [numBits-1:0] quo_q, quo_d;
    logic [numBits-1:0] quotient_q, quotient_d;
    logic [numBits-1:0] remainder_q, remainder_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;

    logic [numBits:0]   step_rem;
    logic               step_q;
    logic [numBits-1:0] min_c;

    assign min_c = numBits'(min_val(numBits));

    div_restore_step #(
        .numBits(numBits)
    ) u_step (
        .partial_rem(rem_q),
        .next_bit   (dvd_q[numBits-1]),
        .divisor_mag(dvs_q),
        .new_rem    (step_rem),
        .q_bit      (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d = numBits'(abs_val(
                        32'(dividend), numBits));
                    dvs_d = numBits'(abs_val(
                        32'(divisor), numBits));
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = CW'(numBits - 1);
                    neg_quo_d  = dividend[numBits-1]
                               ^ divisor[numBits-1];
                    neg_rem_d  = dividend[numBits-1];
                    div_zero_d = (divisor == '0);
                    overflow_d = (dividend == min_c)
                               && (divisor == '1);
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[numBits-2:0], step_q};
                dvd_d = {dvd_q[numBits-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                quotient_d = neg_quo_q
                    ? numBits'(negate(32'(quo_q)))
                    : quo_q;
                remainder_d = neg_rem_q
                    ? numBits'(negate(
                        32'(rem_q[numBits-1:0])))
                    : rem_q[numBits-1:0];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Randomized and directed bench for signed_seq_divider
// against a plain-arithmetic reference model.
module tb_signed_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    signed_seq_divider #(
        .numBits(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ref_div(
        input  logic [3:0] a,
        input  logic [3:0] b,
        output logic [3:0] q,
        output logic [3:0] r,
        output logic       dz,
        output logic       ov
    );
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = 4'hF;
            r  = a;
            dz = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[3:0];
            r  = ri[3:0];
            ov = (ai == -8) && (bi == -1);
        end
    endtask

    task automatic do_op(
        input logic [3:0] a,
        input logic [3:0] b,
        input string      tag
    );
        logic [3:0] eq, er;
        logic       edz, eov;
        int         lat, elat;
        bit         seen;
        ref_div(a, b, eq, er, edz, eov);
        elat = (b == 4'd0) ? 1 : 6;
        for (int i = 0; i < 20 && !in_ready; i++)
            @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready got %b want 1",
                     tag, in_ready);
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat  = i;
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen || lat != elat) begin
            n_fail++;
            $display("FAIL %s latency got %0d want %0d",
                     tag, lat, elat);
        end
        if (seen) begin
            n_cmp++;
            if (quotient !== eq) begin
                n_fail++;
                $display("FAIL %s quotient got %h want %h",
                         tag, quotient, eq);
            end
            n_cmp++;
            if (remainder !== er) begin
                n_fail++;
                $display("FAIL %s remainder got %h want %h",
                         tag, remainder, er);
            end
            n_cmp++;
            if (div_zero !== edz || overflow !== eov) begin
                n_fail++;
                $display("FAIL %s flags got dz=%b ov=%b want dz=%b ov=%b",
                         tag, div_zero, overflow, edz, eov);
            end
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1
                || div_zero !== 1'b0
                || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL %s post_hs got v=%b r=%b dz=%b ov=%b want 0 1 0 0",
                         tag, out_valid, in_ready,
                         div_zero, overflow);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 4'd0;
        divisor   = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || quotient !== 4'd0
            || remainder !== 4'd0 || div_zero !== 1'b0
            || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got v=%b q=%h r=%h dz=%b ov=%b want all 0",
                     out_valid, quotient, remainder,
                     div_zero, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1",
                     in_ready);
        end
    endtask

    task automatic test_directed();
        do_op(4'd7,  4'd2,  "7/2");
        do_op(4'h9,  4'd2,  "-7/2");
        do_op(4'd7,  4'hE,  "7/-2");
        do_op(4'hA,  4'hD,  "-6/-3");
        do_op(4'h8,  4'hF,  "-8/-1");
        do_op(4'h8,  4'd1,  "-8/1");
    endtask

    task automatic test_div_zero();
        do_op(4'd5, 4'd0, "5/0");
        do_op(4'h8, 4'd0, "-8/0");
    endtask

    task automatic test_backpressure();
        bit seen;
        out_ready = 1'b0;
        dividend  = 4'd7;
        divisor   = 4'd2;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_valid got 0 want 1");
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || quotient !== 4'd3
                || remainder !== 4'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b r=%b q=%h rm=%h want 1 0 3 1",
                         i, out_valid, in_ready,
                         quotient, remainder);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got r=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_op(4'd3, 4'd3, "b2b_3/3");
    endtask

    task automatic test_reset_abort();
        int stray;
        dividend = 4'd7;
        divisor  = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || quotient !== 4'd0
            || remainder !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_clear got v=%b q=%h r=%h want 0 0 0",
                     out_valid, quotient, remainder);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL abort_novalid got %0d valid cycles want 0",
                     stray);
        end
        do_op(4'd6, 4'd4, "6/4");
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            do_op(a, b, $sformatf("rnd%0d_%h/%h", i, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
